clk_ratio_monitor: RTL and testbench
====================================

// Module: clk_ratio_monitor
// PURPOSE
//   Receive-side checker for the divided clocks our counter/divider blocks produce.
//   - Samples a divided waveform (sig_in, asynchronous to clk) on the reference clk.
//   - Measures period and high time in clk cycles.
//   - Compares both against expected values and reports per-period match plus a lock flag.
//   - Sits next to each divider instance for bring-up and self-check.
// PARAMETERS
//   CNT_W      8  width of measurement counters and result ports
//   EXP_PERIOD 3  expected period, clk cycles (range 2..2^CNT_W-2)
//   EXP_HIGH   1  expected high time, clk cycles (range 1..EXP_PERIOD-1)
//   TOL        0  allowed +/- deviation, clk cycles, applied to period and high time
//   LOCK_CNT   4  consecutive matching periods required to assert locked (>=1)
// PORTS
//   clk         in   1      reference clock, all logic on posedge
//   rst_n       in   1      asynchronous active-low reset
//   sig_in      in   1      monitored divided waveform, async to clk
//   clr         in   1      sync clear: results, lock state, sticky overflow; FSM to SEEK
//   meas_valid  out  1      1-cycle pulse: new period_cnt/high_cnt/match published
//   period_cnt  out  CNT_W  last measured period, clk cycles
//   high_cnt    out  CNT_W  last measured high time, clk cycles
//   match       out  1      last measurement within tolerance, held until next meas_valid
//   locked      out  1      LOCK_CNT consecutive matches seen
//   overflow    out  1      sticky: period counter saturated without a rising edge
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset state: all outputs 0; FSM=SEEK; synchroniser flops 0; good-count 0.
//   Input path:
//     - Synchroniser: sig_in -> s1 -> s2; s3 <= s2.
//     - rise = s2 & ~s3.
//     - sig_in rising before posedge k => meas_valid high after posedge k+2.
//   FSM states SEEK, MEAS:
//     - SEEK: wait for rise. On rise: per=1, hi=1, go MEAS. No meas_valid on the first edge.
//     - MEAS, non-rise cycle: per++ ; hi++ if s2==1.
//     - MEAS, rise: publish period_cnt<=per, high_cnt<=hi; meas_valid<=1; per<=1, hi<=1.
//   Counting: for a waveform high H cycles of period P, the published values are exactly P and H.
//   Match (registered with the publish):
//     - |per-EXP_PERIOD|<=TOL and (see CONFIGURATION) |hi-EXP_HIGH|<=TOL.
//     - Unsigned compare; compute the difference with the larger operand first.
//   Lock:
//     - On match, good++ saturating at LOCK_CNT; locked<=1 once good==LOCK_CNT (same cycle as meas_valid).
//     - On mismatch, good<=0 and locked<=0 in the meas_valid cycle.
//   Overflow:
//     - per reaching 2^CNT_W-1 in MEAS without rise => overflow<=1 (sticky), locked<=0, good<=0, FSM->SEEK.
//     - No meas_valid is issued for it.
//     - sig_in stuck high or stuck low both end this way.
//   hi saturates at 2^CNT_W-1 and never wraps.
//   clr has priority over rise and overflow in the same cycle; period_cnt/high_cnt/match are also cleared to 0.
//   rst_n deasserted mid-measurement: the partial period is discarded, with no spurious meas_valid after release.
// CONFIGURATION
//   RATIO_MON_DUTY_CHECK_EN
//     - defined: match requires both the period and the high-time checks.
//     - undefined: match is the period check only; high_cnt is still measured and published.
// TESTING
//   T1 P=3,H=1 waveform, defaults -> meas_valid every 3 clk.
//      period_cnt=3, high_cnt=1, match=1; locked=1 on the 4th meas_valid.
//   T2 after lock, one period stretched to P=4 -> that meas_valid shows period_cnt=4, match=0, locked=0.
//      Relock after 4 further P=3 periods.
//   T3 sig_in held low after lock, CNT_W=8 -> overflow=1 and locked=0 255 clk after the last rise.
//      No meas_valid; clr -> overflow=0.
//   T4 P=3,H=2 -> with RATIO_MON_DUTY_CHECK_EN: high_cnt=2, match=0, never locked.
//      Without it: match=1, locked after 4.
//   T5 TOL=1, alternating P=3/P=4 -> match=1 on every meas_valid, locked after 4.
//   T6 rst_n pulsed low mid-period, then clr asserted with a coincident rise.
//      -> All outputs 0 immediately on reset.
//      -> First meas_valid only one full period after the first post-reset rise.
//      -> clr wins over the coincident rise.

Source files
------------

// File: rtl/clk_ratio_monitor.sv
// ============================================================================
// Module   : clk_ratio_monitor
// Summary  : Measures the period and high time of a divided clock on clk,
//            reports per-period match and lock. Optional duty check enabled by
//            defining RATIO_MON_DUTY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_ratio_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 3,
  parameter int EXP_HIGH   = 1,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             match,
  output logic             locked,
  output logic             overflow
);

  localparam int                 C_GOOD_W     = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   C_MAX        = '1;
  localparam logic [CNT_W-1:0]   C_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0]   C_EXP_PERIOD = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]   C_TOL        = CNT_W'(TOL);
  localparam logic [C_GOOD_W-1:0] C_LOCK      = C_GOOD_W'(LOCK_CNT);
  localparam logic [C_GOOD_W-1:0] C_GOOD_ONE  = C_GOOD_W'(1);

  typedef enum logic [0:0] {
    SEEK = 1'b0,
    MEAS = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_s1, r_s2, r_s3;
  logic [CNT_W-1:0]    r_per;
  logic [CNT_W-1:0]    r_hi;
  logic [C_GOOD_W-1:0] r_good;

  logic                w_rise;
  logic [CNT_W-1:0]    w_per_diff;
  logic                w_per_ok;
  logic                w_match;
  logic [C_GOOD_W-1:0] w_good_next;

  // Synchroniser runs independently of clr so edge detection stays coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;

`ifdef RATIO_MON_DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] C_EXP_HIGH = CNT_W'(EXP_HIGH);
  logic [CNT_W-1:0] w_hi_diff;
  logic             w_hi_ok;

  always_comb begin
    w_hi_diff = (r_hi >= C_EXP_HIGH) ? (r_hi - C_EXP_HIGH) : (C_EXP_HIGH - r_hi);
    w_hi_ok   = (w_hi_diff <= C_TOL);
  end
`endif

  always_comb begin
    w_per_diff  = (r_per >= C_EXP_PERIOD) ? (r_per - C_EXP_PERIOD) : (C_EXP_PERIOD - r_per);
    w_per_ok    = (w_per_diff <= C_TOL);
`ifdef RATIO_MON_DUTY_CHECK_EN
    w_match     = w_per_ok & w_hi_ok;
`else
    w_match     = w_per_ok;
`endif
    w_good_next = (r_good == C_LOCK) ? C_LOCK : (r_good + C_GOOD_ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SEEK;
      r_per      <= '0;
      r_hi       <= '0;
      r_good     <= '0;
      meas_valid <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      match      <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (clr) begin
        r_state    <= SEEK;
        r_per      <= '0;
        r_hi       <= '0;
        r_good     <= '0;
        period_cnt <= '0;
        high_cnt   <= '0;
        match      <= 1'b0;
        locked     <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        case (r_state)
          SEEK: begin
            // First edge only starts the count; there is no prior period to report.
            if (w_rise) begin
              r_per   <= C_ONE;
              r_hi    <= C_ONE;
              r_state <= MEAS;
            end
          end
          MEAS: begin
            if (w_rise) begin
              period_cnt <= r_per;
              high_cnt   <= r_hi;
              match      <= w_match;
              meas_valid <= 1'b1;
              r_per      <= C_ONE;
              r_hi       <= C_ONE;
              if (w_match) begin
                r_good <= w_good_next;
                locked <= (w_good_next == C_LOCK);
              end else begin
                r_good <= '0;
                locked <= 1'b0;
              end
            end else if (r_per == C_MAX) begin
              overflow <= 1'b1;
              locked   <= 1'b0;
              r_good   <= '0;
              r_state  <= SEEK;
            end else begin
              r_per <= r_per + C_ONE;
              if (r_s2 && (r_hi != C_MAX)) begin
                r_hi <= r_hi + C_ONE;
              end
            end
          end
          default: r_state <= SEEK;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_ratio_monitor.sv
// ============================================================================
// Module   : tb_clk_ratio_monitor
// Summary  : Directed self-checking bench for clk_ratio_monitor (TOL=0 and
//            TOL=1 instances sharing one stimulus waveform).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_ratio_monitor;

  localparam int CNT_W = 8;
`ifdef RATIO_MON_DUTY_CHECK_EN
  localparam logic DUTY_EN = 1'b1;
`else
  localparam logic DUTY_EN = 1'b0;
`endif

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic             sig_in = 1'b0;
  logic             clr    = 1'b0;

  logic             meas_valid, match, locked, overflow;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             meas_valid2, match2, locked2, overflow2;
  logic [CNT_W-1:0] period_cnt2, high_cnt2;

  int               checks = 0;
  int               errors = 0;
  int               mv_cnt = 0;
  int               mv2_cnt = 0;
  int               base;
  int               ovf_at;
  int               pseq [5] = '{3, 4, 3, 4, 3};

  logic [CNT_W-1:0] cap_per, cap_hi, cap2_per;
  logic             cap_match, cap_locked, cap2_match, cap2_locked;

  clk_ratio_monitor #(.CNT_W(CNT_W), .EXP_PERIOD(3), .EXP_HIGH(1), .TOL(0), .LOCK_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .clr(clr),
    .meas_valid(meas_valid), .period_cnt(period_cnt), .high_cnt(high_cnt),
    .match(match), .locked(locked), .overflow(overflow)
  );

  clk_ratio_monitor #(.CNT_W(CNT_W), .EXP_PERIOD(3), .EXP_HIGH(1), .TOL(1), .LOCK_CNT(4)) dut_tol (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .clr(clr),
    .meas_valid(meas_valid2), .period_cnt(period_cnt2), .high_cnt(high_cnt2),
    .match(match2), .locked(locked2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk cycle: drive on negedge, sample just after posedge.
  task automatic tick(input logic v);
    @(negedge clk);
    sig_in = v;
    @(posedge clk);
    #1;
    if (meas_valid) begin
      mv_cnt++;
      cap_per    = period_cnt;
      cap_hi     = high_cnt;
      cap_match  = match;
      cap_locked = locked;
    end
    if (meas_valid2) begin
      mv2_cnt++;
      cap2_per    = period_cnt2;
      cap2_match  = match2;
      cap2_locked = locked2;
    end
  endtask

  task automatic run_period(input int p, input int h);
    for (int i = 0; i < p; i++) tick(i < h);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_mv", meas_valid, 0);
    check("rst_per", period_cnt, 0);
    check("rst_hi", high_cnt, 0);
    check("rst_match", match, 0);
    check("rst_locked", locked, 0);
    check("rst_ovf", overflow, 0);
    tick(0); tick(0);
    rst_n = 1'b1;
    tick(0); tick(0);

    // T1: nominal P=3,H=1, lock on 4th measurement
    run_period(3, 1);
    check("t1_first_edge_no_mv", mv_cnt, 0);
    for (int n = 1; n <= 4; n++) begin
      run_period(3, 1);
      check("t1_mv_cnt", mv_cnt, n);
      check("t1_per", cap_per, 3);
      check("t1_hi", cap_hi, 1);
      check("t1_match", cap_match, 1);
      check("t1_locked", cap_locked, (n == 4));
    end

    // T2: one stretched period breaks lock, then relock
    run_period(4, 1);
    run_period(3, 1);
    check("t2_per", cap_per, 4);
    check("t2_match", cap_match, 0);
    check("t2_locked", cap_locked, 0);
    check("t2_tol_match", cap2_match, 1);
    for (int n = 1; n <= 4; n++) begin
      run_period(3, 1);
      check("t2_relock", cap_locked, (n == 4));
    end

    // T3: input stuck low -> overflow 255 clk after the last rise
    base   = mv_cnt;
    ovf_at = -1;
    for (int t = 3; t < 300; t++) begin
      tick(0);
      if (overflow && ovf_at < 0) ovf_at = t;
    end
    check("t3_ovf_tick", ovf_at, 257);
    check("t3_ovf", overflow, 1);
    check("t3_locked", locked, 0);
    check("t3_no_mv", mv_cnt, base);
    clr = 1'b1;
    tick(0);
    clr = 1'b0;
    check("t3_clr_ovf", overflow, 0);
    check("t3_clr_per", period_cnt, 0);
    check("t3_clr_hi", high_cnt, 0);
    check("t3_clr_match", match, 0);

    // T4: P=3,H=2, duty check decides match
    run_period(3, 2);
    for (int n = 1; n <= 4; n++) begin
      run_period(3, 2);
      check("t4_per", cap_per, 3);
      check("t4_hi", cap_hi, 2);
      check("t4_match", cap_match, !DUTY_EN);
      check("t4_locked", cap_locked, (n == 4) && !DUTY_EN);
    end

    // T5: TOL=1 instance with alternating P=3/P=4
    clr = 1'b1;
    tick(0);
    clr = 1'b0;
    run_period(pseq[0], 1);
    for (int i = 1; i < 5; i++) begin
      run_period(pseq[i], 1);
      check("t5_tol_per", cap2_per, pseq[i-1]);
      check("t5_tol_match", cap2_match, 1);
      check("t5_tol_locked", cap2_locked, (i == 4));
      check("t5_strict_match", cap_match, (pseq[i-1] == 3));
    end

    // T6: asynchronous reset mid-period
    check("t6_pre_lock", locked2, 1);
    tick(1); tick(0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_per", period_cnt, 0);
    check("t6_rst_hi", high_cnt, 0);
    check("t6_rst_match", match, 0);
    check("t6_rst_locked", locked2, 0);
    check("t6_rst_mv", meas_valid, 0);
    tick(0); tick(0);
    rst_n = 1'b1;
    base = mv_cnt;
    tick(0); tick(0); tick(0);
    check("t6_no_spurious", mv_cnt, base);
    run_period(3, 1);
    check("t6_first_edge_no_mv", mv_cnt, base);
    run_period(3, 1);
    check("t6_first_mv", mv_cnt, base + 1);
    check("t6_first_per", cap_per, 3);
    run_period(3, 1); run_period(3, 1); run_period(3, 1);
    check("t6_relocked", cap_locked, 1);

    // T6: clr coincident with a rise wins
    base = mv_cnt;
    tick(1); tick(0);
    clr = 1'b1;
    tick(0);
    clr = 1'b0;
    check("t6_clr_locked", locked, 0);
    check("t6_clr_per", period_cnt, 0);
    run_period(3, 1);
    check("t6_clr_seek", mv_cnt, base);
    run_period(3, 1);
    check("t6_clr_next_mv", mv_cnt, base + 1);
    check("t6_clr_next_per", cap_per, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
